imem_loader: RTL and testbench

//  Writer side of the byte-addressed instruction memory: accepts a byte stream (valid/ready) and

---
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader.sv | 147 ++++++++++++++
 tb/tb_imem_loader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream / instruction-memory write bus for imem_loader.
// The master side is the host link (drives the stream, watches status);
// the slave side is the loader itself.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_last;
  logic              s_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   byte_count;

  modport master (
    output start, s_valid, s_data, s_last,
    input  s_ready, wr_en, wr_addr, wr_data, cpu_reset, busy, done, error, byte_count
  );

  modport slave (
    input  start, s_valid, s_data, s_last,
    output s_ready, wr_en, wr_addr, wr_data, cpu_reset, busy, done, error, byte_count
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: streams bytes into instruction memory at
// addresses 0,1,2,... while holding the core in reset, zero-pads the image
// to a 4-byte boundary and releases the core once the image is complete.
// Optional build macro IMEM_LOADER_CHECKSUM_EN: the s_last byte is an XOR
// checksum over the data bytes instead of image data.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MEM_BYTES = 1024
) (
  input  logic             clk,
  input  logic             reset,   // synchronous, active-low
  imem_loader_if.slave     bus
);

  typedef enum logic [2:0] {IDLE, LOAD, PAD, DONE, ERR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;       // next byte address to write
  logic [ADDR_W:0]   count_inc;  // byte_count after the write being issued now
  logic              fire;
  logic              restart;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        chk;        // running XOR of data bytes
`endif

  // Handshake, next count and restart decode.
  always_comb begin
    fire      = bus.s_valid && bus.s_ready;
    count_inc = bus.byte_count + (ADDR_W+1)'(1);
    restart   = bus.start && (state inside {IDLE, DONE, ERR});
  end

  // Load sequencer with all outputs registered.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      addr           <= '0;
      bus.s_ready    <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.cpu_reset  <= 1'b1;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.error      <= 1'b0;
      bus.byte_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk            <= '0;
`endif
    end else begin
      bus.wr_en <= 1'b0;
      if (restart) begin
        state          <= LOAD;
        addr           <= '0;
        bus.s_ready    <= 1'b1;
        bus.busy       <= 1'b1;
        bus.done       <= 1'b0;
        bus.error      <= 1'b0;
        bus.cpu_reset  <= 1'b1;
        bus.byte_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk            <= '0;
`endif
      end else begin
        case (state)
          LOAD: begin
            if (fire) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              if (bus.s_last) begin
                // Checksum byte: compared, never written or counted.
                bus.s_ready <= 1'b0;
                if (chk != bus.s_data) begin
                  state    <= ERR;
                  bus.busy <= 1'b0;
                end else if (bus.byte_count[1:0] == 2'd0) begin
                  state    <= DONE;
                  bus.busy <= 1'b0;
                end else begin
                  state <= PAD;
                end
              end else begin
                bus.wr_en      <= 1'b1;
                bus.wr_addr    <= addr;
                bus.wr_data    <= bus.s_data;
                addr           <= addr + ADDR_W'(1);
                bus.byte_count <= count_inc;
                chk            <= chk ^ bus.s_data;
                if (addr == LAST_ADDR) begin
                  state       <= ERR;
                  bus.s_ready <= 1'b0;
                  bus.busy    <= 1'b0;
                end
              end
`else
              bus.wr_en      <= 1'b1;
              bus.wr_addr    <= addr;
              bus.wr_data    <= bus.s_data;
              addr           <= addr + ADDR_W'(1);
              bus.byte_count <= count_inc;
              if (bus.s_last) begin
                // Exact fit at the last address is always aligned, so it lands in DONE.
                bus.s_ready <= 1'b0;
                if (count_inc[1:0] == 2'd0) begin
                  state    <= DONE;
                  bus.busy <= 1'b0;
                end else begin
                  state <= PAD;
                end
              end else if (addr == LAST_ADDR) begin
                state       <= ERR;
                bus.s_ready <= 1'b0;
                bus.busy    <= 1'b0;
              end
`endif
            end
          end
          PAD: begin
            bus.wr_en      <= 1'b1;
            bus.wr_addr    <= addr;
            bus.wr_data    <= 8'h00;
            addr           <= addr + ADDR_W'(1);
            bus.byte_count <= count_inc;
            if (count_inc[1:0] == 2'd0) begin
              state    <= DONE;
              bus.busy <= 1'b0;
            end
          end
          DONE: begin
            // Entered together with the final write strobe, so release lags it by one cycle.
            bus.done      <= 1'b1;
            bus.cpu_reset <= 1'b0;
          end
          ERR: begin
            bus.error <= 1'b1;
          end
          default: begin
            // IDLE: wait for start.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver feeds byte images and a
// reference model predicts the memory writes and final status; a separate
// monitor pops predicted writes whenever wr_en is seen.
// Honours IMEM_LOADER_CHECKSUM_EN the same way as the design.
module tb_imem_loader;
  localparam int ADDR_W    = 6;
  localparam int MEM_BYTES = 16;

  typedef struct { logic [ADDR_W-1:0] addr; logic [7:0] data; } wr_t;
  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: what the loader should have done with the accepted bytes.
  wr_t        exp_q[$];
  int         m_count;
  logic [7:0] m_xor;
  bit         m_loading, m_done, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pad_out();
    while (m_count % 4 != 0) begin
      exp_q.push_back('{addr: ADDR_W'(m_count), data: 8'h00});
      m_count++;
    end
  endtask

  // One accepted stream byte applied to the model.
  task automatic model_accept(input logic [7:0] d, input logic last);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (last) begin
      if (d == m_xor) begin
        pad_out();
        m_done = 1;
      end else begin
        m_err = 1;
      end
      m_loading = 0;
      return;
    end
`endif
    exp_q.push_back('{addr: ADDR_W'(m_count), data: d});
    m_xor ^= d;
    m_count++;
    if (last) begin
      pad_out();
      m_done    = 1;
      m_loading = 0;
    end else if (m_count == MEM_BYTES) begin
      m_err     = 1;
      m_loading = 0;
    end
  endtask

  // Monitor: every write strobe must match the next predicted write.
  logic prev_wr_en = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      if (bus.wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_extra: got write addr %0h data %0h, expected none", bus.wr_addr, bus.wr_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
          check("wr_data", 32'(bus.wr_data), 32'(e.data));
        end
        if (!bus.busy && !prev_busy) check("wr_en_outside_load", 32'(bus.wr_en), 0);
      end
`ifndef IMEM_LOADER_CHECKSUM_EN
      if (bus.done && !prev_done) check("done_after_last_wr", 32'(prev_wr_en), 1);
`endif
      prev_wr_en <= bus.wr_en;
      prev_busy  <= bus.busy;
      prev_done  <= bus.done;
    end else begin
      prev_wr_en <= 1'b0;
      prev_busy  <= 1'b0;
      prev_done  <= 1'b0;
    end
  end

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    m_count = 0; m_xor = 8'h00; m_loading = 1; m_done = 0; m_err = 0;
    check("restart_done", 32'(bus.done), 0);
    check("restart_error", 32'(bus.error), 0);
    check("restart_cpu_reset", 32'(bus.cpu_reset), 1);
    check("restart_byte_count", 32'(bus.byte_count), 0);
    check("restart_s_ready", 32'(bus.s_ready), 1);
  endtask

  // gap_mode: 0 back-to-back, 1 random valid + stray start/s_last, 2 toggle every cycle.
  task automatic run_load(input byte_q_t bytes, input bit with_last, input int gap_mode, input bit finish);
    int idx = 0;
    int cyc = 0;
    bit fire;
    do_start();
    while (idx < bytes.size() && m_loading && cyc < 400) begin
      bit v;
      v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? 1'($urandom_range(0, 1)) : (cyc % 2 == 0);
      bus.s_valid = v;
      bus.s_data  = v ? bytes[idx] : 8'($urandom);
      bus.s_last  = v ? (with_last && idx == bytes.size() - 1) : (gap_mode == 1 && $urandom_range(0, 1) == 1);
      bus.start   = (gap_mode == 1) && ($urandom_range(0, 7) == 0);
      @(negedge clk);
      check("s_ready_in_load", 32'(bus.s_ready), 1);
      fire = bus.s_valid && bus.s_ready;
      if (fire) model_accept(bus.s_data, bus.s_last);
      @(posedge clk); #1;
      if (fire) idx++;
      cyc++;
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.start = 1'b0;
    if (!finish) return;
    for (int i = 0; i < 40 && !(bus.done || bus.error); i++) begin
      @(posedge clk); #1;
    end
    check("load_terminated", 32'(bus.done || bus.error), 1);
    check("done", 32'(bus.done), 32'(m_done));
    check("error", 32'(bus.error), 32'(m_err));
    check("cpu_reset", 32'(bus.cpu_reset), 32'(!m_done));
    check("byte_count", 32'(bus.byte_count), 32'(m_count));
    check("busy_end", 32'(bus.busy), 0);
    check("s_ready_end", 32'(bus.s_ready), 0);
    check("writes_pending", 32'(exp_q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
    check("done_held", 32'(bus.done), 32'(m_done));
    check("error_held", 32'(bus.error), 32'(m_err));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 1);
    check({tag, "_s_ready"}, 32'(bus.s_ready), 0);
    check({tag, "_wr_en"}, 32'(bus.wr_en), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_error"}, 32'(bus.error), 0);
    check({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
    check({tag, "_wr_data"}, 32'(bus.wr_data), 0);
    check({tag, "_byte_count"}, 32'(bus.byte_count), 0);
  endtask

  initial begin
    byte_q_t b;
    reset = 1'b0;
    bus.start = 1'b0; bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    reset = 1'b1;
    @(posedge clk); #1;

`ifndef IMEM_LOADER_CHECKSUM_EN
    b = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    run_load(b, 1, 0, 1);
    b = '{8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF};
    run_load(b, 1, 0, 1);
    b = {};
    for (int i = 0; i < MEM_BYTES + 1; i++) b.push_back(8'(i + 1));
    run_load(b, 0, 0, 1);
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(b, 1, 2, 1);
`else
    b = '{8'h01, 8'h02, 8'h04, 8'h07};
    run_load(b, 1, 0, 1);
    b = '{8'h01, 8'h02, 8'h04, 8'h06};
    run_load(b, 1, 0, 1);
`endif

    // Reset in the middle of a load aborts it; the next load starts over at address 0.
    b = '{8'h5A, 8'h5B, 8'h5C};
    run_load(b, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_state("midload_rst");
    exp_q.delete();
    reset = 1'b1;
    @(posedge clk); #1;
    b = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    run_load(b, 1, 0, 1);

    // Random images with random gaps.
    for (int t = 0; t < 12; t++) begin
      int len;
      bit with_last;
      logic [7:0] x;
      b = {};
      x = 8'h00;
`ifdef IMEM_LOADER_CHECKSUM_EN
      len = $urandom_range(0, MEM_BYTES);
      for (int i = 0; i < len; i++) begin
        b.push_back(8'($urandom));
        x ^= b[i];
      end
      b.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'h01) : x);
      with_last = 1;
`else
      len = $urandom_range(1, MEM_BYTES + 1);
      for (int i = 0; i < len; i++) b.push_back(8'($urandom));
      with_last = (len <= MEM_BYTES);
`endif
      run_load(b, with_last, int'($urandom_range(0, 2)), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case something blocks forever.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
